// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_W_DEFAULT = 8;

    // One restoring step per dividend bit.
    function automatic int unsigned div_steps(input int unsigned w);
        return 2 * w;
    endfunction

    // Counter must reach div_steps(w) inclusive.
    function automatic int unsigned div_cnt_w(input int unsigned w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// Single combinational restoring-division step: shift in one dividend bit, trial-subtract.
module div_step
    import divider_pkg::*;
#(
    parameter int unsigned W = DIV_W_DEFAULT
) (
    input  logic [W-1:0] i_pr,
    input  logic         i_dq_msb,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_pr_c,
    output logic         o_q_bit_c
);

    logic [W:0] w_shift;

    assign w_shift = {i_pr, i_dq_msb};

    // The restored remainder is always below the divisor, so W bits hold it.
    always_comb begin
        o_q_bit_c = 1'b0;
        o_pr_c    = w_shift[W-1:0];
        if (w_shift >= {1'b0, i_divisor}) begin
            o_q_bit_c = 1'b1;
            o_pr_c    = W'(w_shift - {1'b0, i_divisor});
        end
    end

endmodule

// File: rtl/divider_sequential.sv
// Multi-cycle radix-2 restoring divider, 2W-bit dividend by W-bit divisor.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient).
module divider_sequential
    import divider_pkg::*;
#(
    parameter int unsigned W = DIV_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*W-1:0]  dividend,
    input  logic [W-1:0]    divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  quotient,
    output logic [W-1:0]    remainder,
    output logic            div_by_zero
);

    localparam int unsigned DW    = 2 * W;
    localparam int unsigned STEPS = div_steps(W);
    localparam int unsigned CW    = div_cnt_w(W);

    div_state_e      r_state;
    logic [W-1:0]    r_pr;
    logic [DW-1:0]   r_dq;
    logic [W-1:0]    r_dvs;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [DW-1:0]   r_quotient;
    logic [W-1:0]    r_remainder;
    logic            r_dbz;

    logic [W-1:0]    w_pr_next;
    logic            w_q_bit;
    logic [DW-1:0]   w_dq_init;
    logic [W-1:0]    w_dvs_init;
    logic [DW-1:0]   w_dbz_q;
    logic [DW-1:0]   w_q_fix;
    logic [W-1:0]    w_r_fix;
    logic            w_accept;

    assign w_accept = in_valid && r_in_ready;

    div_step #(.W(W)) u_div_step (
        .i_pr      (r_pr),
        .i_dq_msb  (r_dq[DW-1]),
        .i_divisor (r_dvs),
        .o_pr_c    (w_pr_next),
        .o_q_bit_c (w_q_bit)
    );

`ifdef DIVIDER_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Magnitudes go through the unsigned core; signs are reapplied on entry to DONE.
    assign w_dq_init  = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
    assign w_dvs_init = divisor[W-1]   ? (~divisor + W'(1))   : divisor;
    assign w_dbz_q    = dividend[DW-1] ? DW'(1) : '1;
    assign w_q_fix    = r_neg_q ? (~r_dq + DW'(1)) : r_dq;
    assign w_r_fix    = r_neg_r ? (~r_pr + W'(1))  : r_pr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_neg_q <= dividend[DW-1] ^ divisor[W-1];
            r_neg_r <= dividend[DW-1];
        end
    end
`else
    assign w_dq_init  = dividend;
    assign w_dvs_init = divisor;
    assign w_dbz_q    = '1;
    assign w_q_fix    = r_dq;
    assign w_r_fix    = r_pr;
`endif

    // Control FSM with step counter and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pr        <= '0;
            r_dq        <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_quotient  <= w_dbz_q;
                            r_remainder <= dividend[W-1:0];
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= CALC;
                            r_dq    <= w_dq_init;
                            r_dvs   <= w_dvs_init;
                            r_pr    <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    if (r_cnt == CW'(STEPS)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                        r_dbz       <= 1'b0;
                    end else begin
                        r_pr  <= w_pr_next;
                        r_dq  <= {r_dq[DW-2:0], w_q_bit};
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    // Result released here; new operands only from the next cycle on.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_sequential.sv
// Directed self-checking bench for divider_sequential (W=8); honours DIVIDER_SIGNED_EN.
module tb_divider_sequential;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    divider_sequential #(.W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; returns edges from accept to out_valid and whether in_ready rose meanwhile.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat, output logic rdy_seen);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 8'h5A;
        rdy_seen = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            rdy_seen = rdy_seen | in_ready;
            tick();
            lat++;
        end
        rdy_seen = rdy_seen | in_ready;
    endtask

    int   lat;
    logic rdy;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_quotient", 32'(quotient), 32'h0);
        check("rst_remainder", 32'(remainder), 32'h0);
        check("rst_dbz", 32'(div_by_zero), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1000 / 7
        out_ready = 1'b1;
        do_op(16'd1000, 8'd7, lat, rdy);
        check("t1_latency", 32'(lat), 32'd17);
        check("t1_quotient", 32'(quotient), 32'd142);
        check("t1_remainder", 32'(remainder), 32'd6);
        check("t1_dbz", 32'(div_by_zero), 32'h0);
        check("t1_in_ready_busy", 32'(rdy), 32'h0);
        tick();
        check("t1_out_valid_released", 32'(out_valid), 32'h0);
        check("t1_in_ready_after", 32'(in_ready), 32'h1);

        // 0xFFFF / 0x01 then 0x00FF / 0xFF
        do_op(16'hFFFF, 8'h01, lat, rdy);
        check("t2a_latency", 32'(lat), 32'd17);
        check("t2a_in_ready_busy", 32'(rdy), 32'h0);
        check("t2a_quotient", 32'(quotient), 32'hFFFF);
        check("t2a_remainder", 32'(remainder), 32'h0);
        tick();
        do_op(16'h00FF, 8'hFF, lat, rdy);
        check("t2b_latency", 32'(lat), 32'd17);
`ifdef DIVIDER_SIGNED_EN
        check("t2b_quotient", 32'(quotient), 32'hFF01);
`else
        check("t2b_quotient", 32'(quotient), 32'h0001);
`endif
        check("t2b_remainder", 32'(remainder), 32'h00);
        tick();

        // 0x1234 / 0: result visible in the cycle right after accept
        do_op(16'h1234, 8'h00, lat, rdy);
        check("t3_latency", 32'(lat), 32'd0);
        check("t3_quotient", 32'(quotient), 32'hFFFF);
        check("t3_remainder", 32'(remainder), 32'h34);
        check("t3_dbz", 32'(div_by_zero), 32'h1);
        tick();
        check("t3_released", 32'(out_valid), 32'h0);

        // Backpressure on 100 / 3 with ignored in_valid pulses
        out_ready = 1'b0;
        do_op(16'd100, 8'd3, lat, rdy);
        check("t4_latency", 32'(lat), 32'd17);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            dividend = 16'd77;
            divisor  = 8'd5;
            tick();
            check("t4_hold_valid", 32'(out_valid), 32'h1);
            check("t4_hold_in_ready", 32'(in_ready), 32'h0);
            check("t4_hold_quotient", 32'(quotient), 32'd33);
            check("t4_hold_remainder", 32'(remainder), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_release_valid", 32'(out_valid), 32'h0);
        check("t4_release_in_ready", 32'(in_ready), 32'h1);

        // Reset in the middle of 500 / 3
        in_valid = 1'b1;
        dividend = 16'd500;
        divisor  = 8'd3;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", 32'(in_ready), 32'h1);
        check("t5_rst_out_valid", 32'(out_valid), 32'h0);
        check("t5_rst_quotient", 32'(quotient), 32'h0);
        check("t5_rst_remainder", 32'(remainder), 32'h0);
        check("t5_rst_dbz", 32'(div_by_zero), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op(16'd9, 8'd2, lat, rdy);
        check("t5_latency", 32'(lat), 32'd17);
        check("t5_quotient", 32'(quotient), 32'd4);
        check("t5_remainder", 32'(remainder), 32'd1);
        tick();

`ifdef DIVIDER_SIGNED_EN
        do_op(16'hFF9C, 8'd7, lat, rdy);
        check("t6a_quotient", 32'(quotient), 32'hFFF2);
        check("t6a_remainder", 32'(remainder), 32'hFE);
        tick();
        do_op(16'd100, 8'hF9, lat, rdy);
        check("t6b_quotient", 32'(quotient), 32'hFFF2);
        check("t6b_remainder", 32'(remainder), 32'h02);
        tick();
        do_op(16'h8000, 8'hFF, lat, rdy);
        check("t6c_quotient", 32'(quotient), 32'h8000);
        check("t6c_remainder", 32'(remainder), 32'h00);
        tick();
        do_op(16'hFF00, 8'h00, lat, rdy);
        check("t6d_quotient", 32'(quotient), 32'h0001);
        check("t6d_remainder", 32'(remainder), 32'h00);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
